cmn_clk_div: RTL

//  Programmable integer clock divider fed by the common clock wire (clk). Produces a registered

---
 rtl/cmn_clk_div_pkg.sv | 22 ++
 rtl/cmn_clk_div_cnt.sv | 46 ++++
 rtl/cmn_clk_div.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cmn_clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmn_clk_div_pkg : shared types and helpers for the programmable divider   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package cmn_clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } cmn_clk_div_state_t;

   localparam int unsigned MIN_DIV = 2;

   // Number of high cycles in a period of n source clocks.
   function automatic int unsigned half_hi(input int unsigned n);
      return (n + 1) >> 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmn_clk_div_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmn_clk_div_cnt : period counter with wrap detect and high/low compare     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cmn_clk_div_cnt
   import cmn_clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic             clr,
   input  logic [CNT_W-1:0] cur_div,
   input  logic [CNT_W-1:0] nxt_div,
   output logic             wrap,
   output logic             hi_nxt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // hi_nxt judges the count about to be registered against the divisor that
   // will govern it, so a divisor change lands cleanly on the period start.
   always_comb begin
      wrap   = (cnt_q == (cur_div - CNT_W'(1)));
      cnt_d  = cnt_q;
      if (clr || (adv && wrap)) begin
         cnt_d = '0;
      end else if (adv) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      hi_nxt = (32'(cnt_d) < half_hi(32'(nxt_div)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cmn_clk_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmn_clk_div : glitch-free programmable integer clock divider with strobes  |
// | Optional rise counter enabled by macro CMN_CLK_DIV_STATS_EN.               |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cmn_clk_div
   import cmn_clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned RST_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             div_req_valid,
   output logic             div_req_ready,
   input  logic [CNT_W-1:0] div_req_val,
   output logic             clk_div_out,
   output logic             rise_stb,
   output logic             fall_stb,
   output logic             busy,
   output logic             div_err,
   output logic [31:0]      rise_cnt
);

   cmn_clk_div_state_t state_q, state_d;
   logic [CNT_W-1:0]   cur_div_q, cur_div_d;
   logic [CNT_W-1:0]   pend_div_q, pend_div_d;
   logic               pend_valid_q, pend_valid_d;
   logic               out_q, out_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic               err_q, err_d;

   logic               xfer;
   logic               legal;
   logic               load;
   logic [CNT_W-1:0]   nxt_div;
   logic               adv;
   logic               clr;
   logic               wrap;
   logic               hi_nxt;

   cmn_clk_div_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .clr     (clr),
      .cur_div (cur_div_q),
      .nxt_div (nxt_div),
      .wrap    (wrap),
      .hi_nxt  (hi_nxt)
   );

   always_comb begin
      xfer         = div_req_valid && !pend_valid_q;
      legal        = (32'(div_req_val) >= MIN_DIV);
      load         = pend_valid_q && ((state_q == IDLE) || wrap);
      nxt_div      = load ? pend_div_q : cur_div_q;

      state_d      = state_q;
      cur_div_d    = cur_div_q;
      pend_div_d   = pend_div_q;
      pend_valid_d = pend_valid_q;
      err_d        = xfer && !legal;
      adv          = 1'b0;
      clr          = 1'b0;
      out_d        = 1'b0;

      if (load) begin
         cur_div_d    = pend_div_q;
         pend_valid_d = 1'b0;
      end
      if (xfer && legal) begin
         pend_div_d   = div_req_val;
         pend_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            clr = 1'b1;
            if (en) begin
               state_d = RUN;
               out_d   = hi_nxt;
            end
         end
         RUN, DRAIN: begin
            // A wrap with en low ends the run; no new period is started.
            if (wrap && !en) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else begin
               state_d = en ? RUN : DRAIN;
               adv     = 1'b1;
               out_d   = hi_nxt;
            end
         end
         default: begin
            state_d = IDLE;
            clr     = 1'b1;
         end
      endcase

      rise_d = out_d && !out_q;
      fall_d = !out_d && out_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cur_div_q    <= CNT_W'(RST_DIV);
         pend_div_q   <= '0;
         pend_valid_q <= 1'b0;
         out_q        <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_div_q    <= cur_div_d;
         pend_div_q   <= pend_div_d;
         pend_valid_q <= pend_valid_d;
         out_q        <= out_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         err_q        <= err_d;
      end
   end

   assign clk_div_out   = out_q;
   assign rise_stb      = rise_q;
   assign fall_stb      = fall_q;
   assign div_err       = err_q;
   assign busy          = (state_q != IDLE);
   assign div_req_ready = !pend_valid_q;

`ifdef CMN_CLK_DIV_STATS_EN
   logic [31:0] rise_cnt_q;
   logic [31:0] rise_cnt_d;

   always_comb begin
      rise_cnt_d = rise_cnt_q + {31'd0, rise_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_cnt_q <= '0;
      end else begin
         rise_cnt_q <= rise_cnt_d;
      end
   end

   assign rise_cnt = rise_cnt_q;
`else
   assign rise_cnt = '0;
`endif

endmodule
`default_nettype wire
